// File: rtl/wave_display_mc.sv
// wave_display_mc
//   Multi-channel pipelined waveform renderer for the VGA path. For every
//   visible pixel it addresses the shared sample RAMs. It then draws line
//   segments between consecutive samples of up to NUM_CH channels, with
//   programmable vertical scale/offset, frame-locked buffer selection and an
//   optional background grid.
//
// Ports
//   clk           pixel clock
//   reset         asynchronous, active-low reset
//   x, y, valid   current pixel from the timing generator
//   read_index    requested display buffer (loaded at frame start)
//   scale_shift   sample right-shift (loaded at frame start)
//   y_offset      vertical offset added after the shift (loaded at frame start)
//   ch_enable     per-channel draw enable
//   grid_en       background grid enable
//   read_address  shared sample-RAM address {buffer, sample index}, combinational
//   read_value    per-channel RAM data, one cycle after read_address, ch0 in LSBs
//   valid_pixel   r/g/b belong to this block for this pixel (2 cycles after x/y)
//   r, g, b       pixel colour
module wave_display_mc #(
    parameter int                   NUM_CH     = 2,
    parameter int                   SAMPLE_W   = 8,
    parameter int                   DEPTH_LOG2 = 8,
    parameter int                   X_START    = 256,
    parameter logic [NUM_CH*24-1:0] CH_COLORS  = {24'h00FF00, 24'hFFFFFF}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [10:0]                  x,
    input  logic [9:0]                   y,
    input  logic                         valid,
    input  logic                         read_index,
    input  logic [1:0]                   scale_shift,
    input  logic [7:0]                   y_offset,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         grid_en,
    output logic [DEPTH_LOG2:0]          read_address,
    input  logic [NUM_CH*SAMPLE_W-1:0]   read_value,
    output logic                         valid_pixel,
    output logic [7:0]                   r,
    output logic [7:0]                   g,
    output logic [7:0]                   b
);

    localparam logic [11:0] WIN_LO     = 12'(X_START);
    localparam logic [11:0] WIN_HI     = 12'(X_START + (2 ** (DEPTH_LOG2 + 1)));
    localparam logic [23:0] GRID_COLOR = 24'h404040;

    // Top 8 bits of the sample, scaled and offset; wraps modulo 256.
    function automatic logic [7:0] adjust_sample(input logic [7:0] s,
                                                 input logic [1:0] sh,
                                                 input logic [7:0] off);
        return (s >> sh) + off;
    endfunction

    // Inclusive test of v against the span between two endpoints in either order.
    function automatic logic in_span(input logic [7:0] v,
                                     input logic [7:0] e0,
                                     input logic [7:0] e1);
        if (e0 <= e1)
            return (v >= e0) && (v <= e1);
        return (v >= e1) && (v <= e0);
    endfunction

    logic                  buf_sel;
    logic [1:0]            shift;
    logic [7:0]            offset;

    logic [10:0]           x_off;
    logic                  in_win;
    logic                  frame_start;

    logic                  vld_p1;
    logic [DEPTH_LOG2:0]   addr_p1;
    logic [7:0]            y_disp_p1;
    logic [4:0]            grid_x_p1;
    logic [DEPTH_LOG2:0]   addr_p2;
    logic                  win_p2;

    logic [NUM_CH-1:0][7:0] adj;
    logic [NUM_CH-1:0][7:0] cur_use;
    logic [NUM_CH-1:0][7:0] prev_use;
    logic [NUM_CH-1:0][7:0] cur_p1;
    logic [NUM_CH-1:0][7:0] prev_p1;
    logic [NUM_CH-1:0]      hit;
    logic                   new_sample;
    logic [23:0]            color;

    logic                   unused_bits;

    // ---- stage 0: window decode, address generation, frame-locked config ----
    assign x_off       = x - 11'(X_START);
    assign in_win      = valid && !y[9] && ({1'b0, x} >= WIN_LO) && ({1'b0, x} < WIN_HI);
    assign frame_start = valid && (x == 11'd0) && (y == 10'd0);
    // Address is forced to zero while reset is held so the RAMs see a quiet bus.
    assign read_address = (in_win && reset) ? {buf_sel, x_off[DEPTH_LOG2:1]} : '0;

    assign unused_bits = ^{y[0], x_off, read_value};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_sel <= 1'b0;
            shift   <= 2'd1;
            offset  <= 8'd32;
        end else if (frame_start) begin
            buf_sel <= read_index;
            shift   <= scale_shift;
            offset  <= y_offset;
        end
    end

    // ---- stage 1: pixel context aligned with read_value ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            y_disp_p1 <= '0;
            grid_x_p1 <= '0;
            addr_p2   <= '0;
            win_p2    <= 1'b0;
        end else begin
            vld_p1    <= in_win;
            addr_p1   <= read_address;
            y_disp_p1 <= y[8:1];
            grid_x_p1 <= x_off[4:0];
            addr_p2   <= addr_p1;
            win_p2    <= vld_p1;
        end
    end

    // A row segment starts whenever the previous stage-1 pixel was not in the
    // window; its prev endpoint collapses onto the fresh sample.
    always_comb begin
        new_sample = vld_p1 && ((addr_p1 != addr_p2) || !win_p2);
        adj        = '0;
        cur_use    = '0;
        prev_use   = '0;
        hit        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            adj[c]      = adjust_sample(read_value[c*SAMPLE_W + SAMPLE_W - 8 +: 8], shift, offset);
            cur_use[c]  = new_sample ? adj[c] : cur_p1[c];
            prev_use[c] = new_sample ? (win_p2 ? cur_p1[c] : adj[c]) : prev_p1[c];
            hit[c]      = ch_enable[c] && vld_p1 && in_span(y_disp_p1, prev_use[c], cur_use[c]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_p1  <= '0;
            prev_p1 <= '0;
        end else if (new_sample) begin
            cur_p1  <= cur_use;
            prev_p1 <= prev_use;
        end
    end

    // Lowest-index hit channel wins, then grid, then black.
    always_comb begin
        color = '0;
        if (grid_en && vld_p1 && ((grid_x_p1 == 5'd0) || (y_disp_p1[4:0] == 5'd0)))
            color = GRID_COLOR;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (hit[c])
                color = CH_COLORS[c*24 +: 24];
        end
    end

    // ---- stage 2: registered pixel output ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_pixel <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            valid_pixel <= vld_p1;
            r           <= color[23:16];
            g           <= color[15:8];
            b           <= color[7:0];
        end
    end

endmodule

// File: tb/tb_wave_display_mc.sv
module tb_wave_display_mc;

    localparam int NUM_CH     = 2;
    localparam int SAMPLE_W   = 8;
    localparam int DEPTH_LOG2 = 8;
    localparam int X_START    = 256;
    localparam int WIN        = 512;
    localparam int DEPTH      = 256;
    localparam logic [23:0] COL0 = 24'hFFFFFF;
    localparam logic [23:0] COL1 = 24'h00FF00;
    localparam logic [23:0] GRID = 24'h404040;

    logic                        clk = 1'b0;
    logic                        reset = 1'b0;
    logic [10:0]                 x = '0;
    logic [9:0]                  y = '0;
    logic                        valid = 1'b0;
    logic                        read_index = 1'b0;
    logic [1:0]                  scale_shift = '0;
    logic [7:0]                  y_offset = '0;
    logic [NUM_CH-1:0]           ch_enable = '0;
    logic                        grid_en = 1'b0;
    logic [DEPTH_LOG2:0]         read_address;
    logic [NUM_CH*SAMPLE_W-1:0]  read_value = '0;
    logic                        valid_pixel;
    logic [7:0]                  r, g, b;

    wave_display_mc #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH_LOG2(DEPTH_LOG2),
        .X_START(X_START), .CH_COLORS({COL1, COL0})
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
        .read_index(read_index), .scale_shift(scale_shift), .y_offset(y_offset),
        .ch_enable(ch_enable), .grid_en(grid_en), .read_address(read_address),
        .read_value(read_value), .valid_pixel(valid_pixel), .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0] mem [NUM_CH][2*DEPTH];

    // Reference model state: frame-locked configuration and current run start.
    int cfg_buf = 0, cfg_shift = 1, cfg_off = 32;
    bit in_reset = 1'b1;
    bit release_pending = 1'b0;
    bit prev_in = 1'b0;
    int run_first = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample RAMs: one-cycle synchronous read.
    always @(posedge clk)
        for (int c = 0; c < NUM_CH; c++)
            read_value[c*SAMPLE_W +: SAMPLE_W] <= mem[c][read_address];

    function automatic int adj_of(int v);
        return ((v >> cfg_shift) + cfg_off) % 256;
    endfunction

    function automatic logic [23:0] model_color(int xv, int yv);
        int n, yd, a, p, lo, hi;
        n  = (xv - X_START) / 2;
        yd = (yv / 2) % 256;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_enable[c]) begin
                a  = adj_of(mem[c][cfg_buf*DEPTH + n]);
                p  = (n > run_first) ? adj_of(mem[c][cfg_buf*DEPTH + n - 1]) : a;
                lo = (a < p) ? a : p;
                hi = (a < p) ? p : a;
                if (yd >= lo && yd <= hi)
                    return (c == 0) ? COL0 : COL1;
            end
        end
        if (grid_en && ((((xv - X_START) % 32) == 0) || ((yd % 32) == 0)))
            return GRID;
        return 24'h0;
    endfunction

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cyc %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic drive_pixel(input int xv, input int yv, input bit vv);
        bit   w;
        int   n;
        int   exp_addr;
        exp_t e;
        @(posedge clk);
        #1;
        if (release_pending) begin
            reset = 1'b1;
            release_pending = 1'b0;
            in_reset = 1'b0;
            prev_in = 1'b0;
        end
        x = 11'(xv);
        y = 10'(yv);
        valid = vv;
        w = vv && !in_reset && (yv < 512) && (xv >= X_START) && (xv < X_START + WIN);
        n = (xv - X_START) / 2;
        if (w) begin
            if (!prev_in) run_first = n;
            e.rgb = model_color(xv, yv);
            e.t   = cyc + 2;
            q.push_back(e);
        end
        prev_in = w;
        exp_addr = w ? (cfg_buf*DEPTH + n) : 0;
        if (vv && xv == 0 && yv == 0 && !in_reset) begin
            cfg_buf   = int'(read_index);
            cfg_shift = int'(scale_shift);
            cfg_off   = int'(y_offset);
        end
        #1;
        check("read_address", int'(read_address), exp_addr);
    endtask

    task automatic run_row(input int yv, input int drop_pct);
        for (int xv = X_START - 3; xv <= X_START + WIN + 1; xv++)
            drive_pixel(xv, yv, $urandom_range(99) >= drop_pct);
    endtask

    task automatic frame_start(input bit ri, input int sh, input int off);
        read_index  = ri;
        scale_shift = 2'(sh);
        y_offset    = 8'(off);
        drive_pixel(0, 0, 1'b0);
        drive_pixel(0, 0, 1'b1);
        drive_pixel(0, 0, 1'b0);
    endtask

    task automatic fill(input int c, input int mode, input int val);
        for (int a = 0; a < 2*DEPTH; a++)
            mem[c][a] = (mode == 0) ? 8'(val) : (mode == 1) ? 8'(a % DEPTH) : 8'($urandom_range(255));
    endtask

    task automatic mid_reset();
        reset = 1'b0;
        in_reset = 1'b1;
        q.delete();
        cfg_buf = 0; cfg_shift = 1; cfg_off = 32;
        prev_in = 1'b0;
        #1;
        check("async_valid_pixel", int'(valid_pixel), 0);
        check("async_rgb", int'({r, g, b}), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].t < cyc) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pixel expected rgb=%h at cyc %0d, valid_pixel was low", mon_e.rgb, mon_e.t);
        end
        if (valid_pixel) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel cyc=%0d rgb=%h", cyc, {r, g, b});
            end else begin
                mon_e = q.pop_front();
                if ({r, g, b} !== mon_e.rgb || cyc != mon_e.t) begin
                    errors++;
                    $display("FAIL pixel got rgb=%h cyc=%0d expected rgb=%h cyc=%0d",
                             {r, g, b}, cyc, mon_e.rgb, mon_e.t);
                end
            end
        end else begin
            checks++;
            if ({r, g, b} !== 24'h0) begin
                errors++;
                $display("FAIL idle_rgb got %h expected 000000 cyc=%0d", {r, g, b}, cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        fill(0, 0, 8'h80);
        fill(1, 2, 0);
        ch_enable   = 2'b01;
        grid_en     = 1'b0;
        read_index  = 1'b1;
        scale_shift = 2'd3;
        y_offset    = 8'd77;

        // Held in reset with live in-window traffic and a frame-start pixel.
        for (int i = 0; i < 4; i++)
            drive_pixel(X_START + $urandom_range(WIN - 1), $urandom_range(511), 1'b1);
        drive_pixel(0, 0, 1'b1);
        release_pending = 1'b1;

        // Shadow defaults: 0x80 -> 96.
        run_row(192, 0);
        run_row(194, 0);

        // Flat trace 0x40 with shift 1, offset 32 -> row y_disp 64.
        fill(0, 0, 8'h40);
        frame_start(1'b0, 1, 32);
        run_row(126, 0);
        run_row(128, 0);
        run_row(129, 0);
        run_row(130, 0);
        run_row(128 + 512, 0);

        // Ramp in buffer 1.
        for (int a = 0; a < DEPTH; a++) mem[0][DEPTH + a] = 8'(a);
        frame_start(1'b1, 0, 0);
        run_row(80, 0);
        run_row(82, 10);

        // Mid-frame config changes must not take effect.
        read_index  = 1'b0;
        scale_shift = 2'd3;
        y_offset    = 8'd200;
        run_row(80, 10);
        frame_start(1'b0, 1, 32);
        run_row(128, 0);

        // Channel priority.
        fill(1, 0, 8'h40);
        ch_enable = 2'b11;
        run_row(128, 0);
        ch_enable = 2'b10;
        run_row(129, 0);

        // Grid with no trace hits.
        ch_enable = 2'b00;
        grid_en   = 1'b1;
        run_row(64, 0);
        run_row(66, 0);
        run_row(600, 0);

        // Reset released in the middle of a row.
        grid_en   = 1'b0;
        ch_enable = 2'b01;
        fill(0, 2, 0);
        for (int xv = X_START - 3; xv <= X_START + 150; xv++) drive_pixel(xv, 140, 1'b1);
        mid_reset();
        for (int xv = X_START + 151; xv <= X_START + 153; xv++) drive_pixel(xv, 140, 1'b1);
        release_pending = 1'b1;
        for (int xv = X_START + 154; xv <= X_START + WIN + 1; xv++) drive_pixel(xv, 140, 1'b1);

        // Randomised frames, including offset wrap and valid drop-outs.
        for (int it = 0; it < 8; it++) begin
            fill(0, 2, 0);
            fill(1, 2, 0);
            frame_start(1'($urandom_range(1)), $urandom_range(3), $urandom_range(255));
            ch_enable = 2'($urandom_range(3));
            grid_en   = 1'($urandom_range(1));
            run_row($urandom_range(1023), 15);
            run_row($urandom_range(511), 15);
        end

        for (int i = 0; i < 6 && q.size() > 0; i++) drive_pixel(0, 5, 1'b0);
        drive_pixel(0, 5, 1'b0);
        check("scoreboard_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
